// File: rtl/ws2812_encoder_pkg.sv
// WS2812 serial LED encoder: shared state encoding and timing defaults.
// Default timing assumes a 25 MHz clock (40 ns per cycle).
package ws2812_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  // 400 ns / 800 ns high, 1.28 us bit, 80 us latch
  localparam int DEF_W       = 24;
  localparam int DEF_T0H     = 10;
  localparam int DEF_T1H     = 20;
  localparam int DEF_T_BIT   = 32;
  localparam int DEF_T_RESET = 2000;
  localparam int DEF_NW      = 10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_encoder_if.sv
// WS2812 encoder signal bundle: frame control, upstream bit feed
// and LED-side outputs, with controller and encoder views.
interface ws2812_encoder_if #(
  parameter int NW = 10
);

  logic          start;
  logic [NW-1:0] num_leds;
  logic          bit_in;
  logic          bit_rqst;
  logic          word_rqst;
  logic          dout;
  logic          busy;
  logic          frame_done;

  modport master (
    output start,
    output num_leds,
    output bit_in,
    input  bit_rqst,
    input  word_rqst,
    input  dout,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  start,
    input  num_leds,
    input  bit_in,
    output bit_rqst,
    output word_rqst,
    output dout,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/ws2812_encoder.sv
// WS2812 encoder: turns an upstream MSB-first bit feed into
// fixed-period high/low pulses, then a latch-low gap per frame.
module ws2812_encoder
  import ws2812_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int T0H     = DEF_T0H,
  parameter int T1H     = DEF_T1H,
  parameter int T_BIT   = DEF_T_BIT,
  parameter int T_RESET = DEF_T_RESET,
  parameter int NW      = DEF_NW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [NW-1:0] num_leds,
  input  logic          bit_in,
  output logic          bit_rqst,
  output logic          word_rqst,
  output logic          dout,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = $clog2(max2(T_BIT, T_RESET) + 1);
  localparam int BW = $clog2(W + 1);

  localparam logic [CW-1:0] H0_END  = CW'(T0H - 1);
  localparam logic [CW-1:0] H1_END  = CW'(T1H - 1);
  localparam logic [CW-1:0] BIT_END = CW'(T_BIT - 1);
  localparam logic [CW-1:0] RST_END = CW'(T_RESET - 1);
  localparam logic [BW-1:0] W_END   = BW'(W - 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [NW-1:0] led_cnt;
  logic [NW-1:0] led_num;
  logic          cur_bit;

  logic hi_bit;
  logic hi_end;
  logic bit_end;
  logic word_end;
  logic frame_end;
  logic accept;

  // cur_bit is only valid after the first HIGH cycle
  assign hi_bit    = (cnt == '0) ? bit_in : cur_bit;
  assign hi_end    = cnt == (hi_bit ? H1_END : H0_END);
  assign bit_end   = cnt == BIT_END;
  assign word_end  = bit_cnt == W_END;
  assign frame_end = (led_cnt + NW'(1)) == led_num;
  assign accept    = start && (num_leds != '0);

  assign busy      = state != S_IDLE;
  assign word_rqst = state == S_LOAD;
  assign bit_rqst  = (state == S_HIGH) && (cnt == '0);

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_LOAD;
      S_LOAD:  state_n = S_HIGH;
      S_HIGH:  if (hi_end) state_n = S_LOW;
      S_LOW: begin
        if (bit_end) begin
          if (!word_end)
            state_n = S_HIGH;
          else if (frame_end)
            state_n = S_LATCH;
          else
            state_n = S_LOAD;
        end
      end
      S_LATCH: if (cnt == RST_END) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state register plus registered line and done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      dout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      dout       <= state_n == S_HIGH;
      frame_done <= (state == S_LATCH) && (state_n == S_IDLE);
    end
  end

  // cycle counter runs across HIGH and LOW so each bit spans T_BIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      unique case (state)
        S_HIGH:  cnt <= cnt + CW'(1);
        S_LOW:   cnt <= bit_end ? '0 : cnt + CW'(1);
        S_LATCH: cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // capture the bit on the cycle its shift is requested
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cur_bit <= 1'b0;
    else if (bit_rqst)
      cur_bit <= bit_in;
  end

  // bits sent within the current word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      bit_cnt <= '0;
    else if (state == S_LOAD)
      bit_cnt <= '0;
    else if ((state == S_LOW) && bit_end)
      bit_cnt <= bit_cnt + BW'(1);
  end

  // frame length latch and words-sent counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_cnt <= '0;
      led_num <= '0;
    end else if ((state == S_IDLE) && accept) begin
      led_cnt <= '0;
      led_num <= num_leds;
    end else if ((state == S_LOW) && bit_end && word_end) begin
      led_cnt <= led_cnt + NW'(1);
    end
  end

endmodule

// File: tb/tb_ws2812_encoder.sv
// Scoreboard bench for ws2812_encoder: expected pulse widths are
// queued by the stimulus and consumed by a line monitor.
module tb_ws2812_encoder;
  import ws2812_pkg::*;

  localparam int SW   = 4;
  localparam int ST0  = 2;
  localparam int ST1  = 4;
  localparam int SBIT = 6;
  localparam int SRST = 10;
  localparam int SNW  = 4;

  logic clk = 1'b0;
  logic rstn;
  logic sel;
  always #5 clk = ~clk;

  ws2812_encoder_if #(.NW(SNW)) sif();
  ws2812_encoder_if #(.NW(DEF_NW)) dif();

  ws2812_encoder #(
    .W(SW), .T0H(ST0), .T1H(ST1),
    .T_BIT(SBIT), .T_RESET(SRST), .NW(SNW)
  ) u_small (
    .clk(clk), .rstn(rstn),
    .start(sif.start), .num_leds(sif.num_leds),
    .bit_in(sif.bit_in), .bit_rqst(sif.bit_rqst),
    .word_rqst(sif.word_rqst), .dout(sif.dout),
    .busy(sif.busy), .frame_done(sif.frame_done)
  );

  ws2812_encoder u_dflt (
    .clk(clk), .rstn(rstn),
    .start(dif.start), .num_leds(dif.num_leds),
    .bit_in(dif.bit_in), .bit_rqst(dif.bit_rqst),
    .word_rqst(dif.word_rqst), .dout(dif.dout),
    .busy(dif.busy), .frame_done(dif.frame_done)
  );

  // upstream shift registers
  logic [SW-1:0] word_q[$];
  logic [SW-1:0] s_sr;
  logic [23:0]   d_sr;
  int n_word;
  int n_bit;

  always @(posedge clk) begin
    if (sif.word_rqst) begin
      n_word++;
      s_sr <= (word_q.size() != 0) ? word_q.pop_front() : '0;
    end else if (sif.bit_rqst) begin
      n_bit++;
      s_sr <= s_sr << 1;
    end
  end
  assign sif.bit_in = s_sr[SW-1];

  always @(posedge clk) begin
    if (dif.word_rqst)
      d_sr <= 24'hCA6FAE;
    else if (dif.bit_rqst)
      d_sr <= d_sr << 1;
  end
  assign dif.bit_in = d_sr[23];

  // scoreboard
  int exp_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb(input int v);
    if (exp_q.size() == 0)
      check("sb_unexpected_event", v, -1);
    else
      check("sb_stream", v, exp_q.pop_front());
  endtask

  // events: high width h, low gap 100+l, frame_done 1000+l
  task automatic push_word(input logic [31:0] word, input int w,
                           input int tb, input int t0, input int t1,
                           input int tr, input bit last);
    int h;
    for (int b = w - 1; b >= 0; b--) begin
      h = word[b] ? t1 : t0;
      exp_q.push_back(h);
      if (b > 0)
        exp_q.push_back(100 + tb - h);
      else if (!last)
        exp_q.push_back(100 + tb - h + 1);
      else
        exp_q.push_back(1000 + tb - h + tr);
    end
  endtask

  wire m_dout = sel ? dif.dout : sif.dout;
  wire m_fd   = sel ? dif.frame_done : sif.frame_done;

  // line monitor
  logic prev;
  int   hic;
  int   lowc;
  bit   seen;
  always @(negedge clk) begin
    if (!rstn) begin
      prev = 1'b0;
      hic  = 0;
      lowc = 0;
      seen = 1'b0;
    end else begin
      if (m_dout) begin
        if (!prev) begin
          if (seen) sb(100 + lowc);
          seen = 1'b1;
          hic  = 0;
        end
        hic++;
      end else begin
        if (prev) begin
          sb(hic);
          lowc = 0;
        end
        lowc++;
      end
      if (m_fd) begin
        sb(1000 + lowc - 1);
        seen = 1'b0;
      end
      prev = m_dout;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_fd && k < budget);
    check(name, int'(m_fd), 1);
    repeat (2) @(negedge clk);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic small_start(input int n);
    @(negedge clk);
    sif.start    = 1'b1;
    sif.num_leds = SNW'(n);
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  initial begin
    int k;
    bit busy_seen;
    rstn = 1'b1;
    sel  = 1'b0;
    sif.start = 1'b0; sif.num_leds = '0;
    dif.start = 1'b0; dif.num_leds = '0;
    #3 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", int'(sif.dout), 0);
    check("rst_busy", int'(sif.busy), 0);
    check("rst_bit_rqst", int'(sif.bit_rqst), 0);
    check("rst_word_rqst", int'(sif.word_rqst), 0);
    check("rst_frame_done", int'(sif.frame_done), 0);
    check("rst_dflt_dout", int'(dif.dout), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // one word 1010: high runs 4,2,4,2 then 10-cycle latch
    n_word = 0; n_bit = 0;
    word_q.push_back(4'b1010);
    push_word(32'hA, SW, SBIT, ST0, ST1, SRST, 1'b1);
    small_start(1);
    check("lat_word_rqst", int'(sif.word_rqst), 1);
    check("lat_busy", int'(sif.busy), 1);
    @(negedge clk);
    check("lat_dout_high", int'(sif.dout), 1);
    check("lat_bit_rqst", int'(sif.bit_rqst), 1);
    wait_done("f1_done", 200);
    check("f1_words", n_word, 1);
    check("f1_bits", n_bit, 4);
    check("f1_idle_busy", int'(sif.busy), 0);

    // three words with a gap cycle between words
    n_word = 0; n_bit = 0;
    word_q.push_back(4'b1010);
    word_q.push_back(4'b0110);
    word_q.push_back(4'b1101);
    push_word(32'hA, SW, SBIT, ST0, ST1, SRST, 1'b0);
    push_word(32'h6, SW, SBIT, ST0, ST1, SRST, 1'b0);
    push_word(32'hD, SW, SBIT, ST0, ST1, SRST, 1'b1);
    small_start(3);
    wait_done("f3_done", 400);
    check("f3_words", n_word, 3);
    check("f3_bits", n_bit, 12);

    // zero-length frame is ignored
    n_word = 0; n_bit = 0;
    busy_seen = 1'b0;
    small_start(0);
    repeat (6) begin
      @(negedge clk);
      if (sif.busy) busy_seen = 1'b1;
    end
    check("n0_busy", int'(busy_seen), 0);
    check("n0_words", n_word, 0);

    // restart request during HIGH is ignored
    n_word = 0; n_bit = 0;
    word_q.push_back(4'b0011);
    word_q.push_back(4'b1000);
    push_word(32'h3, SW, SBIT, ST0, ST1, SRST, 1'b0);
    push_word(32'h8, SW, SBIT, ST0, ST1, SRST, 1'b1);
    small_start(2);
    k = 0;
    while (!sif.dout && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("restart_saw_high", int'(sif.dout), 1);
    sif.start = 1'b1;
    sif.num_leds = SNW'(3);
    @(negedge clk);
    sif.start = 1'b0;
    wait_done("restart_done", 300);
    check("restart_words", n_word, 2);
    check("restart_bits", n_bit, 8);

    // async reset during the second bit
    n_word = 0; n_bit = 0;
    word_q.push_back(4'b1111);
    push_word(32'hF, SW, SBIT, ST0, ST1, SRST, 1'b1);
    small_start(1);
    k = 0;
    while (n_bit < 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("mid_second_bit", n_bit, 2);
    check("mid_dout_high", int'(sif.dout), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_dout", int'(sif.dout), 0);
    check("mid_rst_busy", int'(sif.busy), 0);
    exp_q.delete();
    word_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_word = 0; n_bit = 0;
    word_q.push_back(4'b0011);
    push_word(32'h3, SW, SBIT, ST0, ST1, SRST, 1'b1);
    small_start(1);
    wait_done("post_rst_done", 200);
    check("post_rst_words", n_word, 1);
    check("post_rst_bits", n_bit, 4);

    // default timing, word CA6FAE MSB first
    sel = 1'b1;
    @(negedge clk);
    push_word(32'hCA6FAE, 24, DEF_T_BIT, DEF_T0H, DEF_T1H,
              DEF_T_RESET, 1'b1);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.num_leds = 10'd1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done("dflt_done", 4000);
    check("dflt_idle_busy", int'(dif.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
